// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants used by the fetch stage and its bus interface.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IMEM_AW  = 6;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0033;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction-memory port and IF/ID outputs.
interface if_stage_if;
    import riscv_pkg::*;

    logic                stall;
    logic                redirect;
    logic [XLEN-1:0]     redirect_pc;
    logic [IMEM_AW-1:0]  imem_addr;
    logic [31:0]         imem_data;
    logic [XLEN-1:0]     ifid_pc;
    logic [XLEN-1:0]     ifid_pc_plus4;
    logic [31:0]         ifid_inst;
    logic                ifid_valid;

    modport master (
        input  stall, redirect, redirect_pc, imem_data,
        output imem_addr, ifid_pc, ifid_pc_plus4, ifid_inst, ifid_valid
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_data,
        input  imem_addr, ifid_pc, ifid_pc_plus4, ifid_inst, ifid_valid
    );

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter: reset > load (word-aligned) > hold > increment by 4.
module pc_reg #(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic            hold,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= {load_pc[XLEN-1:2], 2'b00};
        end else if (!hold) begin
            pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills IF/ID.
module if_stage #(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter int unsigned     IMEM_AW  = riscv_pkg::IMEM_AW,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC),
    parameter logic [31:0]     NOP_INST = riscv_pkg::NOP_INST
) (
    input  logic          clk,
    input  logic          rst,
    if_stage_if.master    bus
);

    logic [XLEN-1:0] pc;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (bus.redirect),
        .load_pc (bus.redirect_pc),
        .hold    (bus.stall),
        .pc      (pc)
    );

    // Memory only sees the word index, so fetch wraps every 256 bytes.
    assign bus.imem_addr = pc[IMEM_AW+1:2];

    // IF/ID register; a redirect squashes the wrong-path fetch even under stall.
    always_ff @(posedge clk) begin
        if (rst || bus.redirect) begin
            bus.ifid_inst     <= NOP_INST;
            bus.ifid_valid    <= 1'b0;
            bus.ifid_pc       <= '0;
            bus.ifid_pc_plus4 <= '0;
        end else if (!bus.stall) begin
            bus.ifid_inst     <= bus.imem_data;
            bus.ifid_valid    <= 1'b1;
            bus.ifid_pc       <= pc;
            bus.ifid_pc_plus4 <= pc + XLEN'(4);
        end
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined RISC-V core. It owns the program counter and drives the word address into the 64-entry instruction memory. It captures the returned instruction into the IF/ID pipeline register consumed by decode. It also applies stall and branch-redirect requests arriving from downstream stages.

## Interface
Parameters:
- XLEN, 32, datapath / PC width
- IMEM_AW, 6, instruction-memory word-address width (64 words)
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INST, 32'h0000_0033, bubble instruction (add x0, x0, x0)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC and IF/ID (load-use hazard from decode)
- redirect  in  1  taken branch; load PC from redirect_pc
- redirect_pc  in  XLEN  branch target byte address
- imem_addr  out  IMEM_AW  word address to instruction memory
- imem_data  in  32  instruction word returned combinationally for imem_addr
- ifid_pc  out  XLEN  byte address of the instruction in IF/ID
- ifid_pc_plus4  out  XLEN  ifid_pc + 4
- ifid_inst  out  32  instruction held in IF/ID
- ifid_valid  out  1  1 = real instruction, 0 = bubble

## Operation
- Internal register pc (XLEN bits).
- imem_addr = pc[IMEM_AW+1:2], driven combinationally. pc bits above IMEM_AW+1 are ignored by memory, so fetch address wraps every 256 bytes.
- Per rising edge, priority rst > redirect > stall > advance:
  - rst: pc <= RESET_PC; ifid_inst <= NOP_INST; ifid_valid <= 0; ifid_pc <= 0; ifid_pc_plus4 <= 0.
  - redirect: pc <= {redirect_pc[XLEN-1:2], 2'b00}, so target bits [1:0] are discarded. IF/ID is loaded with a bubble: NOP_INST, valid 0, pc fields 0. This squashes the wrong-path instruction, and it applies even if stall is high.
  - stall (redirect low): pc and all IF/ID outputs hold their values.
  - advance: pc <= pc + 4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0). ifid_inst <= imem_data; ifid_pc <= pc; ifid_pc_plus4 <= pc + 4; ifid_valid <= 1.
- No other internal state. rst asserted mid-stream discards everything in flight.

## Timing
- Output reset values: imem_addr = RESET_PC[IMEM_AW+1:2], ifid_inst = NOP_INST, ifid_valid = 0, ifid_pc = 0, ifid_pc_plus4 = 0.
- Fetch latency is 1 cycle: the instruction at pc in cycle N appears on ifid_* in cycle N+1.
- Redirect sampled in cycle N:
  - imem_addr points to the target in cycle N+1.
  - ifid_valid = 0 in cycle N+1.
  - The target instruction appears in IF/ID in cycle N+2.
- Stall held for k cycles freezes imem_addr and ifid_* for exactly k cycles; fetch resumes on the first cycle stall is low.
- All inputs are sampled only at the rising edge. There are no combinational paths from stall/redirect to outputs.

## Structure
- Shared package (riscv_pkg): XLEN, NOP_INST, RESET_PC default, IMEM_AW.
- One natural sub-module, pc_reg: PC register with reset/load/hold/increment.
- The IF/ID register and priority logic stay in if_stage.

## Test plan
- Reset: rst=1 for 2 cycles, then release -> imem_addr=0, ifid_valid=0, ifid_inst=32'h33. One cycle later, ifid_inst = mem[0], ifid_pc=0, ifid_pc_plus4=4, valid=1.
- Straight-line fetch: mem[k] = 32'h1000_0000+k -> on the cycle following k advances, ifid_inst = 32'h1000_0000+k and ifid_pc = 4k. Check through k=13.
- Stall: assert stall for 2 cycles while pc=0x0C -> imem_addr stays 3, ifid_pc stays 0x08 for 2 cycles. Then ifid_pc=0x0C and pc advances to 0x10.
- Redirect: redirect=1, redirect_pc=0x1E while pc=0x18 -> next cycle imem_addr=7 and ifid_valid=0. The following cycle ifid_pc=0x1C and ifid_inst=mem[7].
- Redirect with stall both high -> redirect wins: pc becomes the target and IF/ID becomes a bubble.
- Wrap and reset mid-run:
  - pc=0xFC -> imem_addr=63; next pc=0x100 -> imem_addr=0.
  - rst asserted at pc=0x20 -> next cycle pc=0, ifid_valid=0.
